requant_pipe: RTL and testbench



---
 rtl/accel_mult_pkg.sv | 54 +++++
 rtl/srdhm_q31.sv | 48 ++++
 rtl/requant_pipe.sv | 156 +++++++++++++++
 tb/tb_requant_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_mult_pkg.sv
// Shared constants, types and helpers for the MULT CSR requantization path.
//   REG_WIDTH      : width of CSR config values and accumulator beats
//   OUT_WIDTH      : width of the int8 result
//   REQUANT_STAGES : pipeline depth of requant_pipe
//   requant_cfg_t  : snapshot of the requant config taken at start
package accel_mult_pkg;

  localparam int unsigned REG_WIDTH      = 32;
  localparam int unsigned PROD_WIDTH     = 2 * REG_WIDTH;
  localparam int unsigned OUT_WIDTH      = 8;
  localparam int unsigned SHIFT_WIDTH    = 5;
  localparam int unsigned REQUANT_STAGES = 4;
  localparam int unsigned Q31_FRAC       = 31;

  localparam logic [REG_WIDTH-1:0] INT32_MIN = 32'h8000_0000;
  localparam logic [REG_WIDTH-1:0] INT32_MAX = 32'h7FFF_FFFF;

  // Rounding nudge for the Q31 high multiply (2^30), its negative-product
  // counterpart (1 - 2^30), and the bias that turns an arithmetic shift
  // into truncation toward zero for negative sums.
  localparam logic signed [PROD_WIDTH-1:0] Q31_NUDGE      = 64'sh0000_0000_4000_0000;
  localparam logic signed [PROD_WIDTH-1:0] Q31_NEG_NUDGE  = 64'sd1 - Q31_NUDGE;
  localparam logic signed [PROD_WIDTH-1:0] Q31_TRUNC_BIAS = 64'sh0000_0000_7FFF_FFFF;

  typedef struct packed {
    logic [REG_WIDTH-1:0]   mult;
    logic [REG_WIDTH-1:0]   zp;
    logic [REG_WIDTH-1:0]   act_min;
    logic [REG_WIDTH-1:0]   act_max;
    logic [SHIFT_WIDTH-1:0] ls;
    logic [SHIFT_WIDTH-1:0] rs;
  } requant_cfg_t;

  // Left-shift amount: max(shift, 0) saturated to 31.
  function automatic logic [SHIFT_WIDTH-1:0] decode_lshift(input logic [REG_WIDTH-1:0] shift);
    logic [SHIFT_WIDTH-1:0] amt;
    amt = '0;
    if (!shift[REG_WIDTH-1]) begin
      amt = (shift > 32'd31) ? 5'd31 : SHIFT_WIDTH'(shift);
    end
    return amt;
  endfunction

  // Right-shift amount: max(-shift, 0) saturated to 31 (INT32_MIN safe).
  function automatic logic [SHIFT_WIDTH-1:0] decode_rshift(input logic [REG_WIDTH-1:0] shift);
    logic [SHIFT_WIDTH-1:0] amt;
    amt = '0;
    if (shift[REG_WIDTH-1]) begin
      amt = ($signed(shift) < -32'sd31) ? 5'd31 : SHIFT_WIDTH'(32'd0 - shift);
    end
    return amt;
  endfunction

endpackage

// File: rtl/srdhm_q31.sv
// Registered saturating rounding doubling high multiply (Q31).
//   clk, rst_n : clock, async active-low reset
//   en         : pipeline advance
//   a, b       : signed 32-bit operands
//   h          : registered result, round((a*b)/2^31) with INT32_MIN^2 saturation
module srdhm_q31
  import accel_mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic [REG_WIDTH-1:0] h
);

  logic signed [PROD_WIDTH-1:0] a_ext_c;
  logic signed [PROD_WIDTH-1:0] b_ext_c;
  logic signed [PROD_WIDTH-1:0] ab_c;
  logic signed [PROD_WIDTH-1:0] nudge_c;
  logic signed [PROD_WIDTH-1:0] sum_c;
  logic signed [PROD_WIDTH-1:0] quo_c;
  logic                         sat_c;
  logic [REG_WIDTH-1:0]         h_c;

  // Multiply, nudge, then divide by 2^31 truncating toward zero.
  always_comb begin
    a_ext_c = {{REG_WIDTH{a[REG_WIDTH-1]}}, a};
    b_ext_c = {{REG_WIDTH{b[REG_WIDTH-1]}}, b};
    ab_c    = a_ext_c * b_ext_c;
    nudge_c = ab_c[PROD_WIDTH-1] ? Q31_NEG_NUDGE : Q31_NUDGE;
    sum_c   = ab_c + nudge_c;
    quo_c   = sum_c[PROD_WIDTH-1] ? ((sum_c + Q31_TRUNC_BIAS) >>> Q31_FRAC)
                                  : (sum_c >>> Q31_FRAC);
    // Only INT32_MIN * INT32_MIN overflows the 32-bit result.
    sat_c   = (a == INT32_MIN) && (b == INT32_MIN);
    h_c     = sat_c ? INT32_MAX : REG_WIDTH'(quo_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
    end else if (en) begin
      h <= h_c;
    end
  end

endmodule

// File: rtl/requant_pipe.sv
// Four-stage per-tensor requantizer: int32 accumulator -> int8 result.
//   start, q_mult_pt, q_shift_pt, dst_zp, act_min, act_max : config snapshot
//   acc_valid/acc_ready/acc_data/acc_last                 : accumulator stream in
//   out_valid/out_ready/out_data/out_last                 : int8 stream out
//   done    : pulse the cycle after the out_last handshake
//   cfg_err : pulse when start is rejected because the pipe is busy
module requant_pipe
  import accel_mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] q_mult_pt,
  input  logic [REG_WIDTH-1:0] q_shift_pt,
  input  logic [REG_WIDTH-1:0] dst_zp,
  input  logic [REG_WIDTH-1:0] act_min,
  input  logic [REG_WIDTH-1:0] act_max,
  input  logic                 acc_valid,
  output logic                 acc_ready,
  input  logic [REG_WIDTH-1:0] acc_data,
  input  logic                 acc_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 done,
  output logic                 cfg_err
);

  requant_cfg_t cfg;
  requant_cfg_t cfg_next_c;

  logic en_c;
  logic acc_hs_c;
  logic busy_c;
  logic snap_c;

  logic                 v1, v2, v3;
  logic                 l1, l2, l3;
  logic [REG_WIDTH-1:0] x1;
  logic [REG_WIDTH-1:0] h2;
  logic [REG_WIDTH-1:0] r3;

  logic [REG_WIDTH-1:0] x_c;
  logic [REG_WIDTH-1:0] mask_c;
  logic [REG_WIDTH-1:0] rem_c;
  logic [REG_WIDTH-1:0] thr_c;
  logic [REG_WIDTH-1:0] r_c;
  logic signed [REG_WIDTH:0] sum_c;
  logic signed [REG_WIDTH:0] lo_c;
  logic signed [REG_WIDTH:0] hi_c;
  logic signed [REG_WIDTH:0] v_c;
  logic [OUT_WIDTH-1:0] out_data_c;

  // Whole pipe moves in lock-step; only a held output stalls it.
  assign en_c      = !out_valid || out_ready;
  assign acc_ready = en_c;
  assign acc_hs_c  = acc_valid && en_c;
  assign busy_c    = v1 || v2 || v3 || out_valid;
  assign snap_c    = start && !busy_c && !acc_hs_c;

  // Config snapshot with shift decoded once.
  always_comb begin
    cfg_next_c         = cfg;
    cfg_next_c.mult    = q_mult_pt;
    cfg_next_c.zp      = dst_zp;
    cfg_next_c.act_min = act_min;
    cfg_next_c.act_max = act_max;
    cfg_next_c.ls      = decode_lshift(q_shift_pt);
    cfg_next_c.rs      = decode_rshift(q_shift_pt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (snap_c) begin
      cfg <= cfg_next_c;
    end
  end

  // Status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      cfg_err <= start && !snap_c;
      done    <= out_valid && out_ready && out_last;
    end
  end

  // S1: pre-multiply left shift (wraps).
  always_comb begin
    x_c = acc_data << cfg.ls;
  end

  // S2: Q31 high multiply.
  srdhm_q31 u_srdhm (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_c),
    .a     (x1),
    .b     (cfg.mult),
    .h     (h2)
  );

  // S3: rounding divide by 2^rs, ties away from zero.
  always_comb begin
    mask_c = (32'd1 << cfg.rs) - 32'd1;
    rem_c  = h2 & mask_c;
    thr_c  = (mask_c >> 1) + {{(REG_WIDTH-1){1'b0}}, h2[REG_WIDTH-1]};
    r_c    = REG_WIDTH'($signed(h2) >>> cfg.rs)
           + {{(REG_WIDTH-1){1'b0}}, (rem_c > thr_c)};
  end

  // S4: zero-point add in 33 bits, then clamp; act_max is applied last.
  always_comb begin
    sum_c = {r3[REG_WIDTH-1], r3} + {cfg.zp[REG_WIDTH-1], cfg.zp};
    lo_c  = {cfg.act_min[REG_WIDTH-1], cfg.act_min};
    hi_c  = {cfg.act_max[REG_WIDTH-1], cfg.act_max};
    v_c   = sum_c;
    if (v_c < lo_c) v_c = lo_c;
    if (v_c > hi_c) v_c = hi_c;
    out_data_c = v_c[OUT_WIDTH-1:0];
  end

  // Stage valids, last flags and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      l3        <= 1'b0;
      out_last  <= 1'b0;
      x1        <= '0;
      r3        <= '0;
      out_data  <= '0;
    end else if (en_c) begin
      v1        <= acc_valid;
      l1        <= acc_valid && acc_last;
      x1        <= x_c;
      v2        <= v1;
      l2        <= l1;
      v3        <= v2;
      l3        <= l2;
      r3        <= r_c;
      out_valid <= v3;
      out_last  <= l3;
      out_data  <= out_data_c;
    end
  end

endmodule

// File: tb/tb_requant_pipe.sv
`timescale 1ns/1ps
module tb_requant_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] q_mult_pt = '0;
  logic [31:0] q_shift_pt = '0;
  logic [31:0] dst_zp = '0;
  logic [31:0] act_min = '0;
  logic [31:0] act_max = '0;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [31:0] acc_data = '0;
  logic        acc_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        done;
  logic        cfg_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int rdy_cyc = 0;
  bit rdy_mode = 1'b0;
  logic hs_last_q = 1'b0;
  logic [8:0] exp_q[$];

  // Bench-side copy of the config the DUT should have snapshotted.
  logic [31:0] m_mult = '0, m_shift = '0, m_zp = '0, m_min = '0, m_max = '0;

  requant_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .q_mult_pt  (q_mult_pt),
    .q_shift_pt (q_shift_pt),
    .dst_zp     (dst_zp),
    .act_min    (act_min),
    .act_max    (act_max),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_last   (acc_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference requantize computed in 64-bit integer arithmetic.
  function automatic logic [7:0] model(input int acc);
    localparam int IMIN = -2147483647 - 1;
    int sh, ls, rs, x, h, r;
    longint ab, nudge, mask, rem, thr, v;
    sh = int'(m_shift);
    ls = (sh > 31) ? 31 : ((sh > 0) ? sh : 0);
    rs = (sh < -31) ? 31 : ((sh < 0) ? -sh : 0);
    x  = acc << ls;
    if (x == IMIN && int'(m_mult) == IMIN) begin
      h = 2147483647;
    end else begin
      ab    = longint'(x) * longint'(int'(m_mult));
      nudge = (ab >= 0) ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30));
      h     = int'((ab + nudge) / (longint'(1) << 31));
    end
    mask = (longint'(1) << rs) - 1;
    rem  = longint'(h) & mask;
    thr  = (mask >> 1) + ((h < 0) ? 1 : 0);
    r    = (h >>> rs) + ((rem > thr) ? 1 : 0);
    v    = longint'(r) + longint'(int'(m_zp));
    if (v < longint'(int'(m_min))) v = longint'(int'(m_min));
    if (v > longint'(int'(m_max))) v = longint'(int'(m_max));
    return v[7:0];
  endfunction

  // Output readiness: always on, or 1-on/2-off.
  always @(posedge clk) begin
    #1;
    rdy_cyc++;
    out_ready = (rdy_mode == 1'b0) || (rdy_cyc % 3 == 0);
  end

  // Scoreboard, flow-control and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_last_q = 1'b0;
    end else begin
      chk("acc_ready_eq_en", 32'(acc_ready), 32'(!out_valid || out_ready));
      chk("done_timing", 32'(done), 32'(hs_last_q));
      if (done) n_done++;
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[7:0]));
          chk("out_last", 32'(out_last), 32'(e[8]));
        end
      end
      hs_last_q = out_valid && out_ready && out_last;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [7:0] exp);
    int   n;
    logic took;
    n    = 0;
    took = 1'b0;
    acc_valid = 1'b1;
    acc_data  = d;
    acc_last  = last;
    while (!took && n < 200) begin
      @(negedge clk);
      took = acc_ready;
      if (took) exp_q.push_back({last, exp});
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) chk("send_accepted", 32'(took), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cycles(1);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    cycles(2);
  endtask

  task automatic set_cfg(input logic [31:0] mult, input logic [31:0] shift,
                         input logic [31:0] zp, input logic [31:0] mn, input logic [31:0] mx);
    q_mult_pt  = mult;
    q_shift_pt = shift;
    dst_zp     = zp;
    act_min    = mn;
    act_max    = mx;
    start      = 1'b1;
    cycles(1);
    start   = 1'b0;
    m_mult  = mult;
    m_shift = shift;
    m_zp    = zp;
    m_min   = mn;
    m_max   = mx;
    @(negedge clk);
    chk("cfg_err_idle", 32'(cfg_err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_acc_ready", 32'(acc_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_cfg_err",   32'(cfg_err),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(1);

    // Basic scaling plus 4-cycle latency.
    set_cfg(32'h4000_0000, 32'd0, 32'd0, 32'(-128), 32'd127);
    send(32'd100, 1'b0, 8'd50);
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("latency_c%0d", k), 32'(out_valid), 32'(k == 4));
    end
    @(posedge clk);
    #1;
    send(32'd3, 1'b0, 8'd2);
    send(32'(-3), 1'b1, 8'hFF);
    idle();
    drain();

    // Right shift and zero-point: -12.5 rounds away from zero to -13.
    set_cfg(32'h4000_0000, 32'(-2), 32'd10, 32'(-128), 32'd127);
    send(32'd100, 1'b0, 8'd23);
    send(32'(-100), 1'b1, 8'(-3));
    idle();
    drain();

    // Left shift with output clamp.
    set_cfg(32'h7FFF_FFFF, 32'd1, 32'd0, 32'(-128), 32'd127);
    send(32'd1000, 1'b0, 8'd127);
    send(32'(-1000), 1'b1, 8'h80);
    idle();
    drain();

    // INT32_MIN * INT32_MIN saturates.
    set_cfg(32'h8000_0000, 32'd0, 32'd0, 32'(-128), 32'd127);
    send(32'h8000_0000, 1'b1, 8'd127);
    idle();
    drain();

    // Narrow activation range.
    set_cfg(32'h7FFF_FFFF, 32'd1, 32'd0, 32'(-20), 32'd20);
    send(32'd1000, 1'b0, 8'd20);
    send(32'(-1000), 1'b1, 8'(-20));
    idle();
    drain();

    // Inverted range: act_max wins.
    set_cfg(32'h4000_0000, 32'd0, 32'd0, 32'd30, 32'(-30));
    send(32'd100, 1'b0, 8'(-30));
    send(32'(-100), 1'b1, 8'(-30));
    idle();
    drain();

    // Shift of INT32_MIN decodes to a right shift of 31.
    set_cfg(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'(-128), 32'd127);
    send(32'h7FFF_FFFF, 1'b1, 8'd1);
    idle();
    drain();

    // Backpressured stream with a rejected mid-stream start and CSR churn.
    set_cfg(32'h5A00_0000, 32'(-1), 32'(-5), 32'(-100), 32'd100);
    rdy_mode = 1'b1;
    n_done   = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          int a;
          a = int'($urandom) >>> 23;
          send(32'(a), i == 15, model(a));
        end
        idle();
      end
      begin
        cycles(8);
        q_mult_pt  = 32'h1000_0000;
        q_shift_pt = 32'd3;
        dst_zp     = 32'd50;
        start      = 1'b1;
        cycles(1);
        start = 1'b0;
        @(negedge clk);
        chk("cfg_err_busy", 32'(cfg_err), 32'd1);
        @(negedge clk);
        chk("cfg_err_pulse_end", 32'(cfg_err), 32'd0);
        act_min = 32'd0;
        act_max = 32'd1;
      end
    join
    drain();
    rdy_mode = 1'b0;
    chk("done_count", 32'(n_done), 32'd1);

    // Reset with three beats in flight.
    set_cfg(32'h4000_0000, 32'd0, 32'd3, 32'(-128), 32'd127);
    send(32'd10, 1'b0, model(10));
    send(32'd20, 1'b0, model(20));
    send(32'd30, 1'b1, model(30));
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_acc_ready", 32'(acc_ready), 32'd1);
    chk("post_rst_done",      32'(done),      32'd0);
    @(posedge clk);
    #1;
    cycles(4);
    send(32'd5, 1'b1, 8'd0);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
